sdram_burst_adapter: RTL and testbench

- Host-side front end for the 4M×16 SDRAM controller.
- Accepts one read or write request at a time over a valid/ready handshake and buffers a full write burst before issuing it.
- Drives the controller's command/data_address/data_write inputs and tracks data_write_done / data_read_valid to detect start and completion.
- Returns read beats to the host with a last marker.

---
 rtl/sdram_burst_adapter.sv | 258 +++++++++++++++++++++++++
 tb/tb_sdram_burst_adapter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_adapter.sv
// sdram_burst_adapter
// Host-side front end for the 4Mx16 SDRAM controller. One read or write
// request is accepted at a time. A write burst is fully buffered before the
// write command is issued. Read beats are returned to the host with a last
// marker.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   req_valid/req_ready   request handshake; req_write selects write (1) or read (0)
//   req_address           burst start word address
//   wr_valid/wr_ready     write beat handshake, wr_data = beat
//   rd_valid/rd_data      read beat (single-cycle pulse, no backpressure)
//   rd_last               marks the final beat of a complete read burst
//   busy                  an access is in progress (or controller sync pending)
//   error                 sticky: controller beat count differed from BURST_LENGTH
//   command               to controller: 0 idle, 1 write, 2 read
//   data_address          to controller: latched burst address
//   data_write            to controller: write beat selected from the buffer
//   data_read, data_read_valid, data_write_done  from controller
module sdram_burst_adapter #(
    parameter int BURST_LENGTH = 4,
    parameter int ADDR_WIDTH   = 22,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  error,
    output logic [1:0]            command,
    output logic [ADDR_WIDTH-1:0] data_address,
    output logic [DATA_WIDTH-1:0] data_write,
    input  logic [DATA_WIDTH-1:0] data_read,
    input  logic                  data_read_valid,
    input  logic                  data_write_done
);

    // Counter must reach BURST_LENGTH so surplus read beats can be detected.
    localparam int CW = $clog2(BURST_LENGTH + 1);
    localparam int IW = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BURST_LENGTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LENGTH - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(BURST_LENGTH - 1);

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_COLLECT,
        S_ISSUE_WR,
        S_WRITING,
        S_ISSUE_RD,
        S_READING
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              cmd_q, cmd_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_last_q, rd_last_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    error_q, error_d;
    logic                    buf_we;

    // Write burst buffer: one register per beat, not reset (contents are
    // don't-care until a full burst has been collected).
    logic [BURST_LENGTH-1:0][DATA_WIDTH-1:0] wbuf_view;

    genvar gi;
    generate
        for (gi = 0; gi < BURST_LENGTH; gi++) begin : g_buf
            logic [DATA_WIDTH-1:0] ent_q, ent_d;

            always_comb begin
                ent_d = ent_q;
                if (buf_we && (cnt_q[IW-1:0] == IW'(gi))) begin
                    ent_d = wr_data;
                end
            end

            always_ff @(posedge clk) begin
                ent_q <= ent_d;
            end

            assign wbuf_view[gi] = ent_q;
        end
    endgenerate

    // Write data look-ahead: while data_write_done is high the controller is
    // sampling the next beat, so present buf[cnt + done], clamped to the last.
    logic [CW:0]   wsum;
    logic [IW-1:0] widx;

    always_comb begin
        wsum = {1'b0, cnt_q} + {{CW{1'b0}}, data_write_done};
        widx = '0;
        if (state_q == S_ISSUE_WR || state_q == S_WRITING) begin
            if (wsum >= {1'b0, CNT_LAST}) begin
                widx = IDX_LAST;
            end else begin
                widx = wsum[IW-1:0];
            end
        end
    end

    assign data_write = wbuf_view[widx];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        cmd_d      = cmd_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_data_d  = rd_data_q;
        error_d    = error_q;
        buf_we     = 1'b0;

        case (state_q)
            // The controller has no reset: wait until it is visibly quiet.
            S_SYNC: begin
                if (!data_write_done && !data_read_valid) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_address;
                    cnt_d  = '0;
                    if (req_write) begin
                        state_d = S_COLLECT;
                    end else begin
                        state_d = S_ISSUE_RD;
                        cmd_d   = CMD_READ;
                    end
                end
            end

            S_COLLECT: begin
                if (wr_valid) begin
                    buf_we = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_ISSUE_WR;
                        cmd_d   = CMD_WRITE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            // Command is dropped on the first done so the controller cannot
            // start a second burst when it returns to idle.
            S_ISSUE_WR: begin
                if (data_write_done) begin
                    cmd_d   = CMD_IDLE;
                    cnt_d   = CNT_ONE;
                    state_d = S_WRITING;
                end
            end

            S_WRITING: begin
                if (data_write_done) begin
                    if (cnt_q != CNT_FULL) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ISSUE_RD: begin
                if (data_read_valid) begin
                    cmd_d      = CMD_IDLE;
                    state_d    = S_READING;
                    rd_valid_d = 1'b1;
                    rd_data_d  = data_read;
                    rd_last_d  = (cnt_q == CNT_LAST);
                    cnt_d      = cnt_q + CNT_ONE;
                end
            end

            S_READING: begin
                if (data_read_valid) begin
                    if (cnt_q < CNT_FULL) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = data_read;
                        rd_last_d  = (cnt_q == CNT_LAST);
                        cnt_d      = cnt_q + CNT_ONE;
                    end else begin
                        // Surplus beat from the controller: dropped.
                        error_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                    if (cnt_q < CNT_FULL) begin
                        // Short burst: no rd_last was ever produced.
                        error_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_SYNC;
                cmd_d   = CMD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_SYNC;
            cnt_q      <= '0;
            addr_q     <= '0;
            cmd_q      <= CMD_IDLE;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            cmd_q      <= cmd_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
            error_q    <= error_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign wr_ready     = (state_q == S_COLLECT);
    assign busy         = (state_q != S_IDLE);
    assign command      = cmd_q;
    assign data_address = addr_q;
    assign rd_valid     = rd_valid_q;
    assign rd_last      = rd_last_q;
    assign rd_data      = rd_data_q;
    assign error        = error_q;

endmodule

// File: tb/tb_sdram_burst_adapter.sv
// Testbench for sdram_burst_adapter: a small SDRAM controller model answers
// the adapter's commands; the expected host-side read stream and error flag
// are derived from the beats the controller model emits.
module tb_sdram_burst_adapter;

    localparam int BL  = 4;
    localparam int AW  = 22;
    localparam int DW  = 16;
    localparam int INF = 32'h7fffffff;

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_address;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic          error;
    logic [1:0]    command;
    logic [AW-1:0] data_address;
    logic [DW-1:0] data_write;
    logic [DW-1:0] data_read;
    logic          data_read_valid;
    logic          data_write_done;

    sdram_burst_adapter #(
        .BURST_LENGTH(BL),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_address    (req_address),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_last        (rd_last),
        .busy           (busy),
        .error          (error),
        .command        (command),
        .data_address   (data_address),
        .data_write     (data_write),
        .data_read      (data_read),
        .data_read_valid(data_read_valid),
        .data_write_done(data_write_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- controller model ----------------
    int            cyc = 0;
    int            m_mode = 0;     // 0 idle, 1 writing, 2 read wait, 3 reading
    int            m_n, m_w, m_idx;
    int            ctl_delay = 0;
    int            ctl_nbeats = BL;
    int            ctl_wr_steps = BL;
    logic [DW-1:0] ctl_vals [8];
    logic [DW-1:0] wlog [16];
    int            wlog_n = 0;
    logic [AW-1:0] wlog_addr;
    logic [1:0]    s_cmd;
    logic [DW-1:0] s_dw;
    logic [AW-1:0] s_addr;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;
    beat_t exp_q [$];
    int    err_due = INF;

    task emit;
        data_read_valid = 1'b1;
        data_read       = ctl_vals[m_idx];
        if (m_idx < BL)
            exp_q.push_back('{due: cyc + 1, data: ctl_vals[m_idx], last: (m_idx == BL - 1)});
        else if (err_due > cyc + 1)
            err_due = cyc + 1;
        m_idx++;
        m_mode = 3;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            err_due = INF;
            exp_q.delete();
        end
        #1;
        case (m_mode)
            0: begin
                if (s_cmd == 2'd1) begin
                    wlog[0]         = s_dw;
                    wlog_addr       = s_addr;
                    m_n             = 1;
                    wlog_n          = 1;
                    data_write_done = 1'b1;
                    m_mode          = 1;
                end else if (s_cmd == 2'd2) begin
                    m_idx  = 0;
                    m_w    = ctl_delay;
                    m_mode = 2;
                    if (m_w == 0) emit();
                end
            end
            1: begin
                if (m_n < 16) wlog[m_n] = s_dw;
                m_n++;
                wlog_n = m_n;
                if (m_n >= ctl_wr_steps) begin
                    data_write_done = 1'b0;
                    m_mode = 0;
                end
            end
            2: begin
                m_w--;
                if (m_w == 0) emit();
            end
            default: begin
                if (m_idx < ctl_nbeats) emit();
                else begin
                    data_read_valid = 1'b0;
                    m_mode = 0;
                    if (ctl_nbeats < BL && err_due > cyc + 1) err_due = cyc + 1;
                end
            end
        endcase
    end

    // ---------------- compare process ----------------
    logic [DW-1:0] obs_d [16];
    logic          obs_l [16];
    int            obs_n = 0;

    always @(negedge clk) begin
        beat_t b;
        s_cmd  = command;
        s_dw   = data_write;
        s_addr = data_address;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            b = exp_q.pop_front();
            chk("rd_valid_beat", rd_valid, 1);
            chk("rd_data_beat", rd_data, b.data);
            chk("rd_last_beat", rd_last, b.last);
        end else begin
            chk("rd_valid_quiet", rd_valid, 0);
        end
        chk("error_flag", error, (cyc >= err_due));
        chk("ready_vs_busy", req_ready, !busy);
        chk("command_legal", (command == 2'd3), 0);
        if (rd_valid && obs_n < 16) begin
            obs_d[obs_n] = rd_data;
            obs_l[obs_n] = rd_last;
            obs_n++;
        end
    end

    // ---------------- host-side tasks ----------------
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic write_start(input logic [AW-1:0] addr, input logic [BL-1:0][DW-1:0] d, input bit gap);
        req_valid = 1; req_write = 1; req_address = addr;
        tick;
        req_valid = 0;
        chk("wr_addr_latched", data_address, addr);
        chk("wr_ready_collect", wr_ready, 1);
        for (int i = 0; i < BL; i++) begin
            wr_valid = 1; wr_data = d[i];
            tick;
            if (i == 1 && gap) begin
                wr_valid = 0; wr_data = 16'hDEAD;
                tick;
                chk("cmd_idle_in_gap", command, 0);
            end
            if (i == BL - 2) chk("cmd_idle_before_last", command, 0);
        end
        wr_valid = 0;
        chk("cmd_write_after_last", command, 1);
        chk("wr_ready_off", wr_ready, 0);
    endtask

    task automatic write_finish(input logic [AW-1:0] addr, input logic [BL-1:0][DW-1:0] d);
        bit prev, seen, bad, done;
        prev = 0; seen = 0; bad = 0; done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            tick;
            if (seen && command == 2'd1) bad = 1;
            if (data_write_done) seen = 1;
            if (prev && !data_write_done) begin
                chk("busy_at_done_fall", busy, 1);
                tick;
                chk("busy_after_done_fall", busy, 0);
                done = 1;
            end
            prev = data_write_done;
        end
        if (!done) chk("write_timeout", 0, 1);
        chk("no_cmd1_after_done", bad, 0);
        chk("wlog_count", wlog_n, BL);
        chk("wlog_addr", wlog_addr, addr);
        for (int i = 0; i < BL; i++) chk("wlog_beat", wlog[i], d[i]);
    endtask

    task automatic read_start(input logic [AW-1:0] addr, input int delay, input int nbeats, input bit hold);
        bit bad;
        ctl_delay = delay; ctl_nbeats = nbeats; obs_n = 0;
        req_valid = 1; req_write = 0; req_address = addr;
        tick;
        req_valid = 0;
        chk("rd_cmd_issue", command, 2);
        chk("rd_addr_latched", data_address, addr);
        chk("rd_busy", busy, 1);
        if (hold) begin
            bad = 0;
            for (int k = 0; k < 40; k++) begin
                tick;
                if (command != 2'd2 || req_ready || rd_valid) bad = 1;
            end
            chk("refresh_hold", bad, 0);
        end
    endtask

    task automatic read_finish;
        bit found;
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (data_read_valid) found = 1;
            else tick;
        end
        if (!found) chk("read_start_timeout", 0, 1);
        else begin
            chk("cmd_at_first_dv", command, 2);
            tick;
            chk("cmd_clear_after_dv", command, 0);
        end
        for (int k = 0; k < 100 && busy; k++) tick;
        chk("read_done", busy, 0);
    endtask

    task automatic check_reset_outputs;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 1);
        chk("rst_error", error, 0);
        chk("rst_command", command, 0);
        chk("rst_data_address", data_address, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [BL-1:0][DW-1:0] wd;
        logic [DW-1:0]         ev [4];
        bit                    bad, got;

        reset_n = 0; req_valid = 0; req_write = 0; req_address = '0;
        wr_valid = 0; wr_data = '0; data_read = '0;
        data_read_valid = 0; data_write_done = 0;
        repeat (3) tick;
        check_reset_outputs();
        reset_n = 1;
        tick;
        chk("sync_to_idle_ready", req_ready, 1);
        chk("sync_to_idle_busy", busy, 0);

        // 1: write with a one-cycle gap after beat 1
        wd = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
        write_start(22'h12345, wd, 1);
        write_finish(22'h12345, wd);

        // 2: read at the top address
        ctl_vals[0] = 16'h1111; ctl_vals[1] = 16'h2222;
        ctl_vals[2] = 16'h3333; ctl_vals[3] = 16'h4444;
        ev[0] = 16'h1111; ev[1] = 16'h2222; ev[2] = 16'h3333; ev[3] = 16'h4444;
        read_start(22'h3FFFFF, 0, 4, 0);
        read_finish();
        chk("rd_count", obs_n, 4);
        for (int i = 0; i < 4; i++) begin
            chk("rd_lit_data", obs_d[i], ev[i]);
            chk("rd_lit_last", obs_l[i], (i == 3));
        end

        // 3: controller busy with refresh for 40 cycles
        ctl_vals[0] = 16'h0A01; ctl_vals[1] = 16'h0A02;
        ctl_vals[2] = 16'h0A03; ctl_vals[3] = 16'h0A04;
        read_start(22'h00100, 40, 4, 1);
        read_finish();
        chk("refresh_rd_count", obs_n, 4);
        chk("refresh_rd_first", obs_d[0], 16'h0A01);
        chk("refresh_no_error", error, 0);

        // 4: controller emits one beat too many
        ctl_vals[0] = 16'h0B00; ctl_vals[1] = 16'h0B01; ctl_vals[2] = 16'h0B02;
        ctl_vals[3] = 16'h0B03; ctl_vals[4] = 16'h0B04;
        read_start(22'h00200, 2, 5, 0);
        read_finish();
        chk("extra_rd_count", obs_n, 4);
        chk("extra_rd_last_data", obs_d[3], 16'h0B03);
        chk("extra_rd_last_flag", obs_l[3], 1);
        chk("extra_error_set", error, 1);
        wd = {16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0};
        write_start(22'h00777, wd, 0);
        write_finish(22'h00777, wd);
        chk("error_sticky", error, 1);
        reset_n = 0;
        tick;
        check_reset_outputs();
        reset_n = 1;
        tick;
        chk("post_reset_ready", req_ready, 1);

        // 5: reset while the controller is mid-write and keeps done high
        ctl_wr_steps = 6;
        wd = {16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0};
        write_start(22'h00200, wd, 0);
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            tick;
            if (data_write_done) got = 1;
        end
        chk("midwrite_done_seen", got, 1);
        tick;
        reset_n = 0;
        tick;
        check_reset_outputs();
        tick;
        reset_n = 1;
        bad = 0; got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick;
            if (data_write_done && req_ready) bad = 1;
            if (req_ready) got = 1;
        end
        chk("sync_hold_while_done", bad, 0);
        chk("sync_release", got, 1);
        ctl_wr_steps = BL;

        // 6: back-to-back write then read
        ctl_vals[0] = 16'h5A01; ctl_vals[1] = 16'h5A02;
        ctl_vals[2] = 16'h5A03; ctl_vals[3] = 16'h5A04;
        wd = {16'h00D3, 16'h00D2, 16'h00D1, 16'h00D0};
        write_start(22'h00055, wd, 0);
        ctl_delay = 0; ctl_nbeats = 4; obs_n = 0;
        req_valid = 1; req_write = 0; req_address = 22'h00AAA;
        write_finish(22'h00055, wd);
        tick;
        req_valid = 0;
        chk("b2b_busy", busy, 1);
        chk("b2b_cmd_read", command, 2);
        chk("b2b_addr", data_address, 22'h00AAA);
        read_finish();
        chk("b2b_rd_count", obs_n, 4);
        chk("b2b_rd_last_data", obs_d[3], 16'h5A04);
        chk("b2b_rd_last_flag", obs_l[3], 1);

        tick;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
